bp_be_dcache_pkt_encoder: RTL and testbench
===========================================

BP_BE_DCACHE_PKT_ENCODER -- requirements
Module: bp_be_dcache_pkt_encoder

Interface
REQ-001 SHALL have parameter: bp_params_p, e_bp_default_cfg, processor configuration (supplies vaddr_width_p, dword_width_gp, reg_addr_width_gp).
REQ-002 SHALL have port: clk_i  input  1  clock.
REQ-003 SHALL have port: reset_n_i  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port: flush_i  input  1  synchronous buffer clear.
REQ-005 SHALL have port: req_v_i  input  1  request valid.
REQ-006 SHALL have port: req_ready_and_o  output  1  request accepted when high with req_v_i.
REQ-007 SHALL have ports, all inputs, meaning decoded request fields:
- load_i 1
- store_i 1
- size_i 2 (0 byte, 1 half, 2 word, 3 double)
- unsigned_i 1
- float_i 1
- lr_i 1
- sc_i 1
- fencei_i 1
- amo_subop_i $bits(bp_be_amo_subop_e)
- rd_addr_i reg_addr_width_gp
- vaddr_i vaddr_width_p
- data_i dword_width_gp
REQ-008 SHALL have port: pkt_v_o  output  1  packet valid.
REQ-009 SHALL have port: pkt_o  output  $bits(bp_be_dcache_pkt_s)  encoded dcache packet.
REQ-010 SHALL have port: pkt_ready_and_i  input  1  consumer ready.
REQ-011 SHALL have port: illegal_o  output  1  one-cycle pulse, rejected request.

Function
REQ-012 SHALL classify each accepted request as exactly one class; more than one, or none, is illegal:
- fencei (fencei_i)
- lr (lr_i)
- sc (sc_i)
- amo (amo_subop_i != e_dcache_subop_none)
- load (load_i & !store_i)
- store (store_i & !load_i)
REQ-013 SHALL encode fencei as e_dcache_op_fencei; size ignored.
REQ-014 SHALL encode lr/sc by size: word -> lrw/scw, double -> lrd/scd; byte/half illegal.
REQ-015 SHALL encode amo by subop and size: word -> e_dcache_op_amo<op>w, double -> amo<op>d; byte/half illegal.
REQ-016 SHALL encode integer loads: lb/lh/lw/ld; with unsigned_i, lbu/lhu/lwu; unsigned double illegal.
REQ-017 SHALL encode integer stores sb/sh/sw/sd; store with unsigned_i illegal.
REQ-018 SHALL encode float: load word/double -> flw/fld, store word/double -> fsw/fsd; float with byte/half, unsigned_i, fencei, lr, sc or amo illegal.
REQ-019 SHALL copy rd_addr_i, vaddr_i, data_i unchanged into the corresponding pkt_o fields.
REQ-020 SHALL buffer legal packets in a 2-entry FIFO; req_ready_and_o = (count < 2), independent of pkt_ready_and_i.
REQ-021 SHALL assert pkt_v_o = (count != 0); pkt_o = head entry; dequeue on pkt_v_o & pkt_ready_and_i.
REQ-022 SHALL make a legal request accepted at edge N visible on pkt_v_o in cycle after N (1-cycle latency); no combinational req->pkt path.
REQ-023 SHALL handle simultaneous enqueue and dequeue so count is unchanged and order is preserved.
REQ-024 SHALL consume an illegal accepted request without enqueueing it and pulse illegal_o for exactly the following cycle.
REQ-025 SHALL, on flush_i, empty the FIFO at the next edge; a request presented during flush is dropped (no enqueue, no illegal_o); a dequeue in that cycle is discarded.
REQ-026 SHALL wrap the read/write pointers modulo 2.

Reset
REQ-027 SHALL, while reset_n_i is low, asynchronously clear count and pointers, and drive pkt_v_o=0 and illegal_o=0; req_ready_and_o=1 after reset release.
REQ-028 SHALL discard buffer contents on reset mid-operation; payload storage need not be reset.

Verification
REQ-029 SHALL cover: load_i=1, size=1, unsigned_i=1, rd_addr=5 -> next cycle pkt_v_o=1, opcode e_dcache_op_lhu, rd_addr=5.
REQ-030 SHALL cover: amo_subop=amoadd, size=3 -> amoaddd; same with size=0 -> illegal_o pulse, pkt_v_o stays 0.
REQ-031 SHALL cover: pkt_ready_and_i=0, three back-to-back legal requests (sw, ld, fsd) -> req_ready_and_o low after two; on drain, output order sw, ld, then fsd.
REQ-032 SHALL cover: count=1 with enqueue and dequeue in the same cycle -> count stays 1, new packet is next.
REQ-033 SHALL cover: flush_i with count=2 and req_v_i=1 -> pkt_v_o=0 next cycle, no illegal_o.
REQ-034 SHALL cover: reset_n_i asserted mid-stream, asynchronously -> pkt_v_o=0 immediately, req_ready_and_o=1 after release.

Source files
------------

// File: rtl/bp_be_dcache_pkt_encoder.sv
// Dcache packet encoder: classifies a decoded memory request, encodes the
// dcache opcode and buffers legal packets in a 2-entry FIFO.

package bp_be_dcache_pkt_encoder_pkg;

  typedef enum logic [0:0] {e_bp_default_cfg = 1'b0} bp_params_e;

  function automatic int unsigned cfg_vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

  function automatic int unsigned cfg_dword_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 64;
      default:          return 64;
    endcase
  endfunction

  function automatic int unsigned cfg_reg_addr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 5;
      default:          return 5;
    endcase
  endfunction

  localparam int unsigned vaddr_width_gp    = cfg_vaddr_width(e_bp_default_cfg);
  localparam int unsigned dword_width_gp    = cfg_dword_width(e_bp_default_cfg);
  localparam int unsigned reg_addr_width_gp = cfg_reg_addr_width(e_bp_default_cfg);

  typedef enum logic [3:0] {
    e_dcache_subop_none    = 4'd0,
    e_dcache_subop_amoswap = 4'd1,
    e_dcache_subop_amoadd  = 4'd2,
    e_dcache_subop_amoxor  = 4'd3,
    e_dcache_subop_amoand  = 4'd4,
    e_dcache_subop_amoor   = 4'd5,
    e_dcache_subop_amomin  = 4'd6,
    e_dcache_subop_amomax  = 4'd7,
    e_dcache_subop_amominu = 4'd8,
    e_dcache_subop_amomaxu = 4'd9
  } bp_be_amo_subop_e;

  typedef enum logic [5:0] {
    e_dcache_op_lb       = 6'd0,
    e_dcache_op_lh       = 6'd1,
    e_dcache_op_lw       = 6'd2,
    e_dcache_op_ld       = 6'd3,
    e_dcache_op_lbu      = 6'd4,
    e_dcache_op_lhu      = 6'd5,
    e_dcache_op_lwu      = 6'd6,
    e_dcache_op_sb       = 6'd7,
    e_dcache_op_sh       = 6'd8,
    e_dcache_op_sw       = 6'd9,
    e_dcache_op_sd       = 6'd10,
    e_dcache_op_lrw      = 6'd11,
    e_dcache_op_scw      = 6'd12,
    e_dcache_op_lrd      = 6'd13,
    e_dcache_op_scd      = 6'd14,
    e_dcache_op_amoswapw = 6'd15,
    e_dcache_op_amoaddw  = 6'd16,
    e_dcache_op_amoxorw  = 6'd17,
    e_dcache_op_amoandw  = 6'd18,
    e_dcache_op_amoorw   = 6'd19,
    e_dcache_op_amominw  = 6'd20,
    e_dcache_op_amomaxw  = 6'd21,
    e_dcache_op_amominuw = 6'd22,
    e_dcache_op_amomaxuw = 6'd23,
    e_dcache_op_amoswapd = 6'd24,
    e_dcache_op_amoaddd  = 6'd25,
    e_dcache_op_amoxord  = 6'd26,
    e_dcache_op_amoandd  = 6'd27,
    e_dcache_op_amoord   = 6'd28,
    e_dcache_op_amomind  = 6'd29,
    e_dcache_op_amomaxd  = 6'd30,
    e_dcache_op_amominud = 6'd31,
    e_dcache_op_amomaxud = 6'd32,
    e_dcache_op_flw      = 6'd33,
    e_dcache_op_fld      = 6'd34,
    e_dcache_op_fsw      = 6'd35,
    e_dcache_op_fsd      = 6'd36,
    e_dcache_op_fencei   = 6'd37
  } bp_be_dcache_fu_op_e;

  typedef struct packed {
    bp_be_dcache_fu_op_e           opcode;
    logic [reg_addr_width_gp-1:0]  rd_addr;
    logic [vaddr_width_gp-1:0]     vaddr;
    logic [dword_width_gp-1:0]     data;
  } bp_be_dcache_pkt_s;

endpackage

module bp_be_dcache_pkt_encoder
  import bp_be_dcache_pkt_encoder_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  localparam int unsigned vaddr_width_p  = cfg_vaddr_width(bp_params_p),
  localparam int unsigned dword_width_p  = cfg_dword_width(bp_params_p),
  localparam int unsigned reg_addr_width_p = cfg_reg_addr_width(bp_params_p),
  localparam int unsigned subop_width_p  = $bits(bp_be_amo_subop_e),
  localparam int unsigned pkt_width_p    = $bits(bp_be_dcache_pkt_s)
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        flush_i,
  input  logic                        req_v_i,
  output logic                        req_ready_and_o,
  input  logic                        load_i,
  input  logic                        store_i,
  input  logic [1:0]                  size_i,
  input  logic                        unsigned_i,
  input  logic                        float_i,
  input  logic                        lr_i,
  input  logic                        sc_i,
  input  logic                        fencei_i,
  input  logic [subop_width_p-1:0]    amo_subop_i,
  input  logic [reg_addr_width_p-1:0] rd_addr_i,
  input  logic [vaddr_width_p-1:0]    vaddr_i,
  input  logic [dword_width_p-1:0]    data_i,
  output logic                        pkt_v_o,
  output logic [pkt_width_p-1:0]      pkt_o,
  input  logic                        pkt_ready_and_i,
  output logic                        illegal_o
);

  bp_be_amo_subop_e    subop;
  bp_be_dcache_fu_op_e op;
  bp_be_dcache_pkt_s   pkt_in;
  bp_be_dcache_pkt_s   mem [2];
  logic                legal, is_amo, is_load, is_store, wide, dbl;
  logic [2:0]          n_class;
  logic [1:0]          count;
  logic                wptr, rptr;
  logic                enq, deq, accept;

  assign subop = bp_be_amo_subop_e'(amo_subop_i);

  // Classify the request and pick its opcode; anything not exactly one class is illegal
  always_comb begin
    is_amo   = (subop != e_dcache_subop_none);
    is_load  = load_i & ~store_i;
    is_store = store_i & ~load_i;
    n_class  = 3'(fencei_i) + 3'(lr_i) + 3'(sc_i) + 3'(is_amo) + 3'(is_load) + 3'(is_store);
    wide     = size_i[1];
    dbl      = (size_i == 2'd3);
    legal    = 1'b0;
    op       = e_dcache_op_lb;
    if (n_class == 3'd1) begin
      if (fencei_i) begin
        op    = e_dcache_op_fencei;
        legal = ~float_i;
      end else if (lr_i) begin
        op    = dbl ? e_dcache_op_lrd : e_dcache_op_lrw;
        legal = wide & ~float_i;
      end else if (sc_i) begin
        op    = dbl ? e_dcache_op_scd : e_dcache_op_scw;
        legal = wide & ~float_i;
      end else if (is_amo) begin
        legal = wide & ~float_i;
        case (subop)
          e_dcache_subop_amoswap: op = dbl ? e_dcache_op_amoswapd : e_dcache_op_amoswapw;
          e_dcache_subop_amoadd:  op = dbl ? e_dcache_op_amoaddd  : e_dcache_op_amoaddw;
          e_dcache_subop_amoxor:  op = dbl ? e_dcache_op_amoxord  : e_dcache_op_amoxorw;
          e_dcache_subop_amoand:  op = dbl ? e_dcache_op_amoandd  : e_dcache_op_amoandw;
          e_dcache_subop_amoor:   op = dbl ? e_dcache_op_amoord   : e_dcache_op_amoorw;
          e_dcache_subop_amomin:  op = dbl ? e_dcache_op_amomind  : e_dcache_op_amominw;
          e_dcache_subop_amomax:  op = dbl ? e_dcache_op_amomaxd  : e_dcache_op_amomaxw;
          e_dcache_subop_amominu: op = dbl ? e_dcache_op_amominud : e_dcache_op_amominuw;
          e_dcache_subop_amomaxu: op = dbl ? e_dcache_op_amomaxud : e_dcache_op_amomaxuw;
          default:                legal = 1'b0;
        endcase
      end else if (float_i) begin
        legal = wide & ~unsigned_i;
        if (is_load) op = dbl ? e_dcache_op_fld : e_dcache_op_flw;
        else         op = dbl ? e_dcache_op_fsd : e_dcache_op_fsw;
      end else if (is_load) begin
        legal = 1'b1;
        case (size_i)
          2'd0:    op = unsigned_i ? e_dcache_op_lbu : e_dcache_op_lb;
          2'd1:    op = unsigned_i ? e_dcache_op_lhu : e_dcache_op_lh;
          2'd2:    op = unsigned_i ? e_dcache_op_lwu : e_dcache_op_lw;
          default: begin
            op    = e_dcache_op_ld;
            legal = ~unsigned_i;
          end
        endcase
      end else begin
        legal = ~unsigned_i;
        case (size_i)
          2'd0:    op = e_dcache_op_sb;
          2'd1:    op = e_dcache_op_sh;
          2'd2:    op = e_dcache_op_sw;
          default: op = e_dcache_op_sd;
        endcase
      end
    end
    pkt_in.opcode  = op;
    pkt_in.rd_addr = rd_addr_i;
    pkt_in.vaddr   = vaddr_i;
    pkt_in.data    = data_i;
  end

  assign req_ready_and_o = (count < 2'd2);
  assign pkt_v_o         = (count != 2'd0);
  assign pkt_o           = mem[rptr];
  assign accept          = req_v_i & req_ready_and_o & ~flush_i;
  assign enq             = accept & legal;
  assign deq             = pkt_v_o & pkt_ready_and_i & ~flush_i;

  // FIFO occupancy, pointers and the illegal pulse; flush overrides enqueue and dequeue
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count     <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      count     <= '0;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= accept & ~legal;
      if (enq) wptr <= ~wptr;
      if (deq) rptr <= ~rptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage is not reset; occupancy alone decides what is valid
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= pkt_in;
  end

endmodule

// File: tb/tb_bp_be_dcache_pkt_encoder.sv
// Self-checking bench for bp_be_dcache_pkt_encoder with a queue-based reference model.

module tb_bp_be_dcache_pkt_encoder;
  import bp_be_dcache_pkt_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, flush, req_v, req_ready;
  logic        load, store, uns, flt, lr, sc, fencei;
  logic [1:0]  size;
  logic [3:0]  amo_subop;
  logic [4:0]  rd_addr;
  logic [38:0] vaddr;
  logic [63:0] data;
  logic        pkt_v, pkt_ready, illegal;
  logic [$bits(bp_be_dcache_pkt_s)-1:0] pkt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  bp_be_dcache_pkt_s exp_q[$];
  logic              exp_illegal = 1'b0;

  localparam bp_be_dcache_fu_op_e LD_S [4] = '{e_dcache_op_lb, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld};
  localparam bp_be_dcache_fu_op_e LD_U [3] = '{e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu};
  localparam bp_be_dcache_fu_op_e ST   [4] = '{e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd};
  localparam bp_be_dcache_fu_op_e AMO_W [9] = '{e_dcache_op_amoswapw, e_dcache_op_amoaddw, e_dcache_op_amoxorw,
    e_dcache_op_amoandw, e_dcache_op_amoorw, e_dcache_op_amominw, e_dcache_op_amomaxw, e_dcache_op_amominuw,
    e_dcache_op_amomaxuw};
  localparam bp_be_dcache_fu_op_e AMO_D [9] = '{e_dcache_op_amoswapd, e_dcache_op_amoaddd, e_dcache_op_amoxord,
    e_dcache_op_amoandd, e_dcache_op_amoord, e_dcache_op_amomind, e_dcache_op_amomaxd, e_dcache_op_amominud,
    e_dcache_op_amomaxud};

  always #5 clk = ~clk;

  bp_be_dcache_pkt_encoder #(.bp_params_p(e_bp_default_cfg)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
    .req_v_i(req_v), .req_ready_and_o(req_ready),
    .load_i(load), .store_i(store), .size_i(size), .unsigned_i(uns), .float_i(flt),
    .lr_i(lr), .sc_i(sc), .fencei_i(fencei), .amo_subop_i(amo_subop),
    .rd_addr_i(rd_addr), .vaddr_i(vaddr), .data_i(data),
    .pkt_v_o(pkt_v), .pkt_o(pkt), .pkt_ready_and_i(pkt_ready), .illegal_o(illegal)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding from the class rules; returns 1 when the request is legal
  function automatic bit model_encode(output bp_be_dcache_fu_op_e op);
    int n;
    int idx;
    op = e_dcache_op_lb;
    n = int'(fencei) + int'(lr) + int'(sc) + int'(amo_subop != 4'd0)
      + int'(load && !store) + int'(store && !load);
    if (n != 1) return 1'b0;
    if (flt && (fencei || lr || sc || amo_subop != 4'd0 || uns)) return 1'b0;
    if (fencei) begin op = e_dcache_op_fencei; return 1'b1; end
    if (lr || sc || amo_subop != 4'd0) begin
      if (size < 2'd2) return 1'b0;
      if (lr)      op = (size == 2'd3) ? e_dcache_op_lrd : e_dcache_op_lrw;
      else if (sc) op = (size == 2'd3) ? e_dcache_op_scd : e_dcache_op_scw;
      else begin
        if (amo_subop > 4'd9) return 1'b0;
        idx = int'(amo_subop) - 1;
        op = (size == 2'd3) ? AMO_D[idx] : AMO_W[idx];
      end
      return 1'b1;
    end
    if (flt) begin
      if (size < 2'd2) return 1'b0;
      if (load) op = (size == 2'd3) ? e_dcache_op_fld : e_dcache_op_flw;
      else      op = (size == 2'd3) ? e_dcache_op_fsd : e_dcache_op_fsw;
      return 1'b1;
    end
    if (load) begin
      if (!uns) op = LD_S[size];
      else if (size == 2'd3) return 1'b0;
      else op = LD_U[size];
      return 1'b1;
    end
    if (uns) return 1'b0;
    op = ST[size];
    return 1'b1;
  endfunction

  // One clock: predict, advance, then compare every output against the model
  task automatic step();
    bp_be_dcache_fu_op_e op;
    bp_be_dcache_pkt_s   p;
    bit ok, accept;
    check("req_ready", 128'(req_ready), 128'(exp_q.size() < 2));
    accept = req_v && (exp_q.size() < 2);
    ok = model_encode(op);
    p.opcode = op; p.rd_addr = rd_addr; p.vaddr = vaddr; p.data = data;
    @(posedge clk); #1;
    if (flush) begin
      exp_q.delete();
      exp_illegal = 1'b0;
    end else begin
      if (exp_q.size() > 0 && pkt_ready) void'(exp_q.pop_front());
      if (accept && ok) exp_q.push_back(p);
      exp_illegal = accept && !ok;
    end
    check("pkt_v", 128'(pkt_v), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("pkt", 128'(pkt), 128'(exp_q[0]));
    check("illegal", 128'(illegal), 128'(exp_illegal));
  endtask

  task automatic idle();
    req_v = 0; load = 0; store = 0; size = 0; uns = 0; flt = 0;
    lr = 0; sc = 0; fencei = 0; amo_subop = 0; rd_addr = 0; vaddr = 0; data = 0;
  endtask

  task automatic drive(input logic l, input logic s, input logic [1:0] sz, input logic u, input logic f,
                       input logic lr_, input logic sc_, input logic fi, input bp_be_amo_subop_e sub,
                       input logic [4:0] rd);
    req_v = 1; load = l; store = s; size = sz; uns = u; flt = f;
    lr = lr_; sc = sc_; fencei = fi; amo_subop = sub; rd_addr = rd;
    vaddr = 39'({$urandom, $urandom});
    data  = {$urandom, $urandom};
  endtask

  function automatic bp_be_dcache_fu_op_e head_op();
    bp_be_dcache_pkt_s h;
    h = bp_be_dcache_pkt_s'(pkt);
    return h.opcode;
  endfunction

  initial begin
    bp_be_dcache_pkt_s h;
    int kind;
    idle();
    flush = 0; pkt_ready = 0; reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pkt_v", 128'(pkt_v), 128'(0));
    check("reset_illegal", 128'(illegal), 128'(0));
    @(negedge clk); reset_n = 1;
    #1 check("reset_ready", 128'(req_ready), 128'(1));

    // Unsigned halfword load
    drive(1, 0, 2'd1, 1, 0, 0, 0, 0, e_dcache_subop_none, 5'd5);
    step();
    h = bp_be_dcache_pkt_s'(pkt);
    check("lhu_v", 128'(pkt_v), 128'(1));
    check("lhu_op", 128'(h.opcode), 128'(e_dcache_op_lhu));
    check("lhu_rd", 128'(h.rd_addr), 128'(5));
    idle(); pkt_ready = 1; step();

    // AMO add: double legal, byte illegal
    drive(0, 0, 2'd3, 0, 0, 0, 0, 0, e_dcache_subop_amoadd, 5'd7);
    step();
    check("amoaddd_op", 128'(head_op()), 128'(e_dcache_op_amoaddd));
    idle(); step();
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0, e_dcache_subop_amoadd, 5'd7);
    step();
    check("amo_byte_illegal", 128'(illegal), 128'(1));
    check("amo_byte_no_pkt", 128'(pkt_v), 128'(0));
    idle(); step();
    check("illegal_one_cycle", 128'(illegal), 128'(0));

    // Backpressure and ordering sw, ld, fsd
    pkt_ready = 0;
    drive(0, 1, 2'd2, 0, 0, 0, 0, 0, e_dcache_subop_none, 5'd1); step();
    drive(1, 0, 2'd3, 0, 0, 0, 0, 0, e_dcache_subop_none, 5'd2); step();
    check("full_ready_low", 128'(req_ready), 128'(0));
    drive(0, 1, 2'd3, 0, 1, 0, 0, 0, e_dcache_subop_none, 5'd3); step();
    check("order0_sw", 128'(head_op()), 128'(e_dcache_op_sw));
    pkt_ready = 1; step();
    check("order1_ld", 128'(head_op()), 128'(e_dcache_op_ld));
    step();
    check("simul_count1_v", 128'(pkt_v), 128'(1));
    check("order2_fsd", 128'(head_op()), 128'(e_dcache_op_fsd));
    idle(); step();
    check("drained", 128'(pkt_v), 128'(0));

    // Flush while full with a request pending
    pkt_ready = 0;
    drive(1, 0, 2'd2, 0, 0, 0, 0, 0, e_dcache_subop_none, 5'd4); step();
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0, e_dcache_subop_none, 5'd6); step();
    drive(1, 1, 2'd2, 0, 0, 0, 0, 0, e_dcache_subop_none, 5'd8);
    flush = 1; step();
    check("flush_empty", 128'(pkt_v), 128'(0));
    check("flush_no_illegal", 128'(illegal), 128'(0));
    flush = 0; idle(); step();

    // Asynchronous reset mid-stream
    drive(1, 0, 2'd3, 0, 0, 0, 0, 0, e_dcache_subop_none, 5'd9); step();
    drive(0, 1, 2'd1, 0, 0, 0, 0, 0, e_dcache_subop_none, 5'd10); step();
    idle();
    #2 reset_n = 0;
    #1;
    check("async_rst_pkt_v", 128'(pkt_v), 128'(0));
    check("async_rst_illegal", 128'(illegal), 128'(0));
    exp_q.delete(); exp_illegal = 1'b0;
    @(negedge clk); reset_n = 1;
    #1 check("post_rst_ready", 128'(req_ready), 128'(1));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      kind = $urandom_range(0, 7);
      case (kind)
        0: fencei = 1;
        1: lr = 1;
        2: sc = 1;
        3: amo_subop = 4'($urandom_range(1, 9));
        4: load = 1;
        5: store = 1;
        6: begin load = 1; store = 1; end
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) lr = 1;
      req_v     = ($urandom_range(0, 3) != 0);
      size      = 2'($urandom_range(0, 3));
      uns       = ($urandom_range(0, 3) == 0);
      flt       = ($urandom_range(0, 2) == 0);
      rd_addr   = 5'($urandom);
      vaddr     = 39'({$urandom, $urandom});
      data      = {$urandom, $urandom};
      pkt_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
